// File: rtl/gomoku_move_ctrl.sv
// Gomoku move controller: cursor handling, stone placement and a sequential
// win/draw check that walks one cell per cycle along each of four directions.
//
// Handshake: there is no valid/ready pair; every btn_* and new_game input is a
// one-cycle pulse sampled on posedge clk. A btn_* pulse is accepted only in
// PLAY and is dropped, never queued, while busy=1 or in OVER. new_game is
// accepted in every state and takes priority over everything else.
module gomoku_move_ctrl #(
  parameter int MAP_SIZE = 11,
  parameter int WIN_LEN  = 5
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       new_game,
  input  logic                                       btn_up,
  input  logic                                       btn_down,
  input  logic                                       btn_left,
  input  logic                                       btn_right,
  input  logic                                       btn_place,
  output logic [(MAP_SIZE-1)*(MAP_SIZE-1)-1:0]       board_black,
  output logic [(MAP_SIZE-1)*(MAP_SIZE-1)-1:0]       board_white,
  output logic [3:0]                                 cur_row,
  output logic [3:0]                                 cur_col,
  output logic                                       turn,
  output logic                                       busy,
  output logic [1:0]                                 winner,
  output logic                                       err_occupied,
  output logic [2:0]                                 dbg_state
);

  localparam int         N         = MAP_SIZE - 1;
  localparam int         CELLS     = N * N;
  localparam logic [3:0] MAXC      = 4'(N - 1);
  localparam logic [3:0] CENTER    = 4'(N / 2);
  localparam logic [6:0] N7        = 7'(N);
  localparam logic [6:0] CELLS7    = 7'(CELLS);
  localparam logic [3:0] WL        = 4'(WIN_LEN);
  localparam logic [2:0] LAST_STEP = 3'(WIN_LEN - 1);

  typedef enum logic [2:0] {
    PLAY     = 3'd0,
    CHK_FWD  = 3'd1,
    CHK_BWD  = 3'd2,
    CHK_NEXT = 3'd3,
    OVER     = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CELLS-1:0]   board_b_q, board_b_d, board_w_q, board_w_d;
  logic [3:0]         row_q, row_d, col_q, col_d;
  logic               turn_q, turn_d;
  logic [1:0]         winner_q, winner_d;
  logic               err_q, err_d;
  logic [6:0]         moves_q, moves_d;
  logic [3:0]         lrow_q, lrow_d, lcol_q, lcol_d;
  logic               lcolor_q, lcolor_d;
  logic [1:0]         dir_q, dir_d;
  logic [2:0]         step_q, step_d;
  logic [3:0]         cnt_q, cnt_d;

  logic [6:0]         cur_idx;
  logic               occupied;
  logic signed [4:0]  step5, row_off, col_off, pr, pc;
  logic               in_bounds, probe_hit;
  logic [6:0]         probe_idx;
  logic [3:0]         cnt_inc;

  // Cell under the cursor and whether either colour already holds it.
  always_comb begin
    cur_idx  = {3'b000, row_q} * N7 + {3'b000, col_q};
    occupied = board_b_q[cur_idx] | board_w_q[cur_idx];
  end

  // Probe cell at signed offset step along the current direction; the board
  // is only indexed when the coordinate lies inside the grid.
  always_comb begin
    step5   = $signed({2'b00, step_q});
    row_off = '0;
    col_off = '0;
    case (dir_q)
      2'd0:    col_off = step5;
      2'd1:    row_off = step5;
      2'd2:    begin row_off = step5; col_off = step5;  end
      default: begin row_off = step5; col_off = -step5; end
    endcase
    if (state_q == CHK_BWD) begin
      row_off = -row_off;
      col_off = -col_off;
    end
    pr        = $signed({1'b0, lrow_q}) + row_off;
    pc        = $signed({1'b0, lcol_q}) + col_off;
    in_bounds = (pr >= 5'sd0) && (pr <= $signed({1'b0, MAXC})) &&
                (pc >= 5'sd0) && (pc <= $signed({1'b0, MAXC}));
    probe_idx = in_bounds ? ({3'b000, pr[3:0]} * N7 + {3'b000, pc[3:0]}) : 7'd0;
    probe_hit = in_bounds && (lcolor_q ? board_w_q[probe_idx] : board_b_q[probe_idx]);
    cnt_inc   = cnt_q + 4'd1;
  end

  // Next-state and next-data logic for the whole controller.
  always_comb begin
    state_d   = state_q;
    board_b_d = board_b_q;
    board_w_d = board_w_q;
    row_d     = row_q;
    col_d     = col_q;
    turn_d    = turn_q;
    winner_d  = winner_q;
    err_d     = 1'b0;
    moves_d   = moves_q;
    lrow_d    = lrow_q;
    lcol_d    = lcol_q;
    lcolor_d  = lcolor_q;
    dir_d     = dir_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    if (new_game) begin
      state_d   = PLAY;
      board_b_d = '0;
      board_w_d = '0;
      row_d     = CENTER;
      col_d     = CENTER;
      turn_d    = 1'b0;
      winner_d  = 2'b00;
      moves_d   = '0;
    end else begin
      case (state_q)
        PLAY: begin
          if (btn_place) begin
            if (occupied) begin
              err_d = 1'b1;
            end else begin
              if (turn_q) board_w_d[cur_idx] = 1'b1;
              else        board_b_d[cur_idx] = 1'b1;
              lrow_d   = row_q;
              lcol_d   = col_q;
              lcolor_d = turn_q;
              moves_d  = moves_q + 7'd1;
              dir_d    = 2'd0;
              step_d   = 3'd1;
              cnt_d    = 4'd1;
              state_d  = CHK_FWD;
            end
          end else if (btn_up) begin
            if (row_q != 4'd0) row_d = row_q - 4'd1;
          end else if (btn_down) begin
            if (row_q != MAXC) row_d = row_q + 4'd1;
          end else if (btn_left) begin
            if (col_q != 4'd0) col_d = col_q - 4'd1;
          end else if (btn_right) begin
            if (col_q != MAXC) col_d = col_q + 4'd1;
          end
        end
        CHK_FWD, CHK_BWD: begin
          if (probe_hit && (cnt_inc >= WL)) begin
            winner_d = lcolor_q ? 2'b10 : 2'b01;
            state_d  = OVER;
          end else if (probe_hit && (step_q != LAST_STEP)) begin
            cnt_d  = cnt_inc;
            step_d = step_q + 3'd1;
          end else begin
            if (probe_hit) cnt_d = cnt_inc;
            step_d  = 3'd1;
            state_d = (state_q == CHK_FWD) ? CHK_BWD : CHK_NEXT;
          end
        end
        CHK_NEXT: begin
          if (dir_q == 2'd3) begin
            if (moves_q == CELLS7) begin
              winner_d = 2'b11;
              state_d  = OVER;
            end else begin
              turn_d  = ~turn_q;
              state_d = PLAY;
            end
          end else begin
            dir_d   = dir_q + 2'd1;
            step_d  = 3'd1;
            cnt_d   = 4'd1;
            state_d = CHK_FWD;
          end
        end
        OVER:    state_d = OVER;
        default: state_d = PLAY;
      endcase
    end
  end

  // State and data registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= PLAY;
      board_b_q <= '0;
      board_w_q <= '0;
      row_q     <= CENTER;
      col_q     <= CENTER;
      turn_q    <= 1'b0;
      winner_q  <= 2'b00;
      err_q     <= 1'b0;
      moves_q   <= '0;
      lrow_q    <= '0;
      lcol_q    <= '0;
      lcolor_q  <= 1'b0;
      dir_q     <= '0;
      step_q    <= 3'd1;
      cnt_q     <= 4'd1;
    end else begin
      state_q   <= state_d;
      board_b_q <= board_b_d;
      board_w_q <= board_w_d;
      row_q     <= row_d;
      col_q     <= col_d;
      turn_q    <= turn_d;
      winner_q  <= winner_d;
      err_q     <= err_d;
      moves_q   <= moves_d;
      lrow_q    <= lrow_d;
      lcol_q    <= lcol_d;
      lcolor_q  <= lcolor_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
    end
  end

  assign board_black  = board_b_q;
  assign board_white  = board_w_q;
  assign cur_row      = row_q;
  assign cur_col      = col_q;
  assign turn         = turn_q;
  assign winner       = winner_q;
  assign err_occupied = err_q;
  assign busy         = (state_q == CHK_FWD) || (state_q == CHK_BWD) || (state_q == CHK_NEXT);
  assign dbg_state    = state_q;

endmodule
